// File: rtl/nibble_serial_subtractor_32b_if.sv
// rtl/nibble_serial_subtractor_32b_if.sv - request/result bundle for the nibble-serial subtractor
interface nibble_serial_subtractor_32b_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] D;
   logic             overflow;
   logic             borrow;

   modport master (
      output start, A, B,
      input  ready, busy, done, D, overflow, borrow
   );

   modport slave (
      input  start, A, B,
      output ready, busy, done, D, overflow, borrow
   );
endinterface

// File: rtl/nibble_serial_subtractor_32b.sv
// rtl/nibble_serial_subtractor_32b.sv - multi-cycle A-B using one DIGIT-wide adder slice
// Computes A + ~B + 1 one digit per clock, LSB digit first, with signed overflow and unsigned borrow.
module nibble_serial_subtractor_32b #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   nibble_serial_subtractor_32b_if.slave s_bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_d;
   logic             r_overflow;
   logic             r_borrow;

   logic             w_accept;
   logic             w_last;
   logic [DIGIT:0]   w_sum;
   logic             w_c_msb;
   logic [WIDTH-1:0] w_final;

   assign w_accept = (r_state != S_RUN) && s_bus.start;
   assign w_last   = (r_cnt == CW'(NDIG - 1));
   assign w_sum    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
   // Carry into the digit MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
   assign w_c_msb  = w_sum[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
   assign w_final  = {w_sum[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (s_bus.start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = s_bus.start ? S_RUN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_carry    <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_res      <= '0;
         r_d        <= '0;
         r_overflow <= 1'b0;
         r_borrow   <= 1'b0;
      end else if (w_accept) begin
         r_a     <= s_bus.A;
         r_b     <= ~s_bus.B;
         r_carry <= 1'b1;
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         r_res   <= w_final;
         r_a     <= r_a >> DIGIT;
         r_b     <= r_b >> DIGIT;
         r_carry <= w_sum[DIGIT];
         r_cnt   <= r_cnt + 1'b1;
         if (w_last) begin
            r_d        <= w_final;
            r_overflow <= w_sum[DIGIT] ^ w_c_msb;
            r_borrow   <= ~w_sum[DIGIT];
         end
      end
   end

   assign s_bus.ready    = (r_state != S_RUN);
   assign s_bus.busy     = (r_state == S_RUN);
   assign s_bus.done     = (r_state == S_DONE);
   assign s_bus.D        = r_d;
   assign s_bus.overflow = r_overflow;
   assign s_bus.borrow   = r_borrow;
endmodule

// File: tb/tb_nibble_serial_subtractor_32b.sv
// tb/tb_nibble_serial_subtractor_32b.sv - self-checking bench for nibble_serial_subtractor_32b
module tb_nibble_serial_subtractor_32b;
   logic clk;
   logic rst_n;
   int   nvec;
   int   nmis;

   nibble_serial_subtractor_32b_if #(.WIDTH(32)) bus ();

   nibble_serial_subtractor_32b #(.WIDTH(32), .DIGIT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s_bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d;
      logic        o;
      logic        br;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic        o;
      logic        br;
   } exp_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sd;
      sd   = longint'($signed(a)) - longint'($signed(b));
      e.d  = a - b;
      e.o  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      e.br = (a < b);
      return e;
   endfunction

   function automatic logic [31:0] pick_operand();
      logic [31:0] corners [5];
      corners[0] = 32'h0000_0000;
      corners[1] = 32'h0000_0001;
      corners[2] = 32'h7FFF_FFFF;
      corners[3] = 32'h8000_0000;
      corners[4] = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   // Launch one op from a ready state, return latency, busy-cycle count and results.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                        output int nbusy, output logic [31:0] d, output logic o, output logic br);
      @(negedge clk);
      bus.start = 1'b1;
      bus.A = a;
      bus.B = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.A = $urandom;
      bus.B = $urandom;
      lat = 0;
      nbusy = 0;
      while (!bus.done && lat < 40) begin
         if (bus.busy) nbusy++;
         @(negedge clk);
         lat++;
      end
      d = bus.D;
      o = bus.overflow;
      br = bus.borrow;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   vec_t tbl [6];
   exp_t q[$];

   initial begin
      int lat;
      int nbusy;
      int ndone;
      int pushed;
      int popped;
      int cyc;
      int last_done;
      logic [31:0] d;
      logic o;
      logic br;
      exp_t e;

      tbl[0] = '{32'd5,         32'd3,         32'h0000_0002, 1'b0, 1'b0};
      tbl[1] = '{32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1, 1'b0};
      tbl[2] = '{32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b1};
      tbl[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
      tbl[4] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0};
      tbl[5] = '{32'd0,         32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1};

      nvec = 0;
      nmis = 0;
      bus.start = 1'b0;
      bus.A = '0;
      bus.B = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ready", 32'(bus.ready), 32'd1);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      chk("reset_D", bus.D, 32'd0);
      chk("reset_overflow", 32'(bus.overflow), 32'd0);
      chk("reset_borrow", 32'(bus.borrow), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         do_op(tbl[i].a, tbl[i].b, lat, nbusy, d, o, br);
         chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd8);
         chk($sformatf("tbl%0d_busy_cycles", i), 32'(nbusy), 32'd8);
         chk($sformatf("tbl%0d_D", i), d, tbl[i].d);
         chk($sformatf("tbl%0d_overflow", i), 32'(o), 32'(tbl[i].o));
         chk($sformatf("tbl%0d_borrow", i), 32'(br), 32'(tbl[i].br));
      end

      // Second start mid-RUN must be ignored.
      @(negedge clk);
      bus.start = 1'b1;
      bus.A = 32'd10;
      bus.B = 32'd4;
      @(negedge clk);
      bus.start = 1'b0;
      ndone = 0;
      nbusy = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 2) begin
            bus.start = 1'b1;
            bus.A = 32'd1;
            bus.B = 32'd1;
         end else if (c == 3) begin
            bus.start = 1'b0;
            bus.A = 32'hDEAD_BEEF;
            bus.B = 32'h0BAD_F00D;
         end
         if (bus.busy) nbusy++;
         if (bus.done) begin
            ndone++;
            chk("ignored_start_D", bus.D, 32'd6);
         end
         @(negedge clk);
      end
      chk("ignored_start_done_count", 32'(ndone), 32'd1);
      chk("ignored_start_busy_cycles", 32'(nbusy), 32'd8);

      // Back-to-back stream with start held high, checked against the model.
      pushed = 0;
      popped = 0;
      last_done = -1;
      @(negedge clk);
      bus.start = 1'b1;
      bus.A = pick_operand();
      bus.B = pick_operand();
      for (cyc = 0; cyc < 9500 && popped < 1000; cyc++) begin
         if (bus.done) begin
            if (q.size() == 0) begin
               chk("b2b_unexpected_done", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk($sformatf("b2b%0d_D", popped), bus.D, e.d);
               chk($sformatf("b2b%0d_overflow", popped), 32'(bus.overflow), 32'(e.o));
               chk($sformatf("b2b%0d_borrow", popped), 32'(bus.borrow), 32'(e.br));
            end
            if (last_done >= 0) chk($sformatf("b2b%0d_period", popped), 32'(cyc - last_done), 32'd9);
            last_done = cyc;
            popped++;
         end
         if (bus.ready) begin
            if (bus.start) begin
               q.push_back(model(bus.A, bus.B));
               pushed++;
            end
         end else begin
            bus.A = pick_operand();
            bus.B = pick_operand();
            if (pushed >= 1000) bus.start = 1'b0;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk("b2b_completions", 32'(popped), 32'd1000);

      // Reset during RUN aborts without a done pulse.
      @(negedge clk);
      bus.start = 1'b1;
      bus.A = 32'd100;
      bus.B = 32'd1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_D", bus.D, 32'd0);
      chk("abort_ready", 32'(bus.ready), 32'd1);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         if (bus.done) ndone++;
         @(negedge clk);
      end
      chk("abort_no_done", 32'(ndone), 32'd0);
      chk("abort_D_held", bus.D, 32'd0);
      do_op(32'd100, 32'd1, lat, nbusy, d, o, br);
      chk("post_abort_latency", 32'(lat), 32'd8);
      chk("post_abort_D", d, 32'd99);
      chk("post_abort_borrow", 32'(br), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/nibble_serial_subtractor_32b.md
Name: nibble_serial_subtractor_32b

Overview:
Multi-cycle 32-bit two's-complement subtractor that computes D = A - B as A + ~B + 1. It processes one 4-bit digit per clock, LSB digit first, and reuses a single 4-bit adder slice. It is the inverse-operation companion to the team's 32-bit ripple-carry adder and trades latency for area in datapaths that need subtraction, compare or borrow. It reports signed overflow with the same convention as the adder, plus an unsigned borrow.

Parameters:
- WIDTH, 32, operand and result width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits processed per clock.
- Derived constant NDIG = WIDTH/DIGIT (8 at defaults).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready=1
- A  input  WIDTH  minuend; captured on the accepted start edge
- B  input  WIDTH  subtrahend; captured on the accepted start edge
- ready  output  1  high in IDLE and DONE; a start is accepted only while high
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; D, overflow and borrow are valid and updated
- D  output  WIDTH  result A-B mod 2^WIDTH; holds until the next completion
- overflow  output  1  signed overflow of A-B; holds with D
- borrow  output  1  unsigned borrow (A<B unsigned), equal to ~carry_out; holds with D

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE, digit counter=0, internal carry=0, internal operand and result shift registers=0.
  - Output values during reset: ready=1, busy=0, done=0, D=0, overflow=0, borrow=0.
  - Reset asserted mid-RUN aborts the operation. No done pulse is produced and D keeps its reset value.
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1 at edge n:
  - Latch A into the a-shift register and ~B into the b-shift register.
  - Set carry=1, set counter=0, go to RUN.
- RUN, each edge:
  - sum = a[DIGIT-1:0] + b[DIGIT-1:0] + carry, computed (DIGIT+1) bits wide.
  - Shift the result register right by DIGIT and insert sum[DIGIT-1:0] at the top.
  - Shift the a and b registers right by DIGIT.
  - carry <= sum[DIGIT].
  - Record c_msb, the carry into the MSB of the current digit. It is used only on the last digit.
  - On the edge processing digit NDIG-1, the state goes to DONE and registered outputs load in parallel:
    - D <= final result
    - overflow <= carry_out XOR c_msb
    - borrow <= ~carry_out
- Latency: start accepted at edge n → done=1 in the cycle following edge n+NDIG (edge n+8 at defaults). Exactly NDIG RUN cycles.
- DONE: done=1 for exactly one cycle. ready=1.
  - start=1 in DONE launches a new operation (back-to-back, no IDLE bubble): state goes to RUN and new operands are latched.
  - start=0 in DONE: state goes to IDLE.
- start while busy=1 is ignored. A and B may change freely after the accepting edge without affecting the result.
- D, overflow and borrow change only on a completion edge or on reset. They stay stable during RUN and show the previous result.
- Overflow is equivalent to (A[W-1]!=B[W-1]) && (D[W-1]!=A[W-1]).
- Wrap-around: the result is modulo 2^WIDTH with no saturation.
- A==B gives D=0, borrow=0, overflow=0.

Test Plan:
- A=5, B=3, pulse start → done exactly 8 cycles later; D=0x00000002, overflow=0, borrow=0.
- A=0x80000000, B=1 → D=0x7FFFFFFF, overflow=1, borrow=0.
- A=0, B=1 → D=0xFFFFFFFF, overflow=0, borrow=1. Then A=0x7FFFFFFF, B=0xFFFFFFFF → D=0x80000000, overflow=1, borrow=1.
- Start A=10, B=4. At cycle 3 of RUN assert start with A=1, B=1 and change the A/B inputs → second start ignored; single done with D=6, busy high for 8 cycles.
- Hold start=1 continuously with new operands presented each accepted edge (9-cycle period) → done pulses every 9 cycles, each D correct. Randomized 1000 pairs checked against the A-B reference model, including overflow and borrow.
- Start A=100, B=1, drop rst_n for 1 cycle at RUN cycle 4 → outputs immediately reset (D=0, ready=1), no done pulse. A following op with A=100, B=1 yields D=99.
